// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// A mult/div result is computed combinationally when the op issues and is
// held internally. It is committed to HI/LO after a fixed latency, which
// models the multi-cycle unit for the hazard logic. MTHI/MTLO write HI/LO
// directly in a single cycle.
module md_unit #(
    parameter int MUL_LAT = 5,   // busy cycles for MULT/MULTU, 1..15
    parameter int DIV_LAT = 10   // busy cycles for DIV/DIVU, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_wr;   // pending result is committed (cleared on divide by zero)
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand magnitudes and signs. Signed division is done on magnitudes so
    // 0x80000000 / -1 has a defined result independent of tool behaviour.
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_dvsr;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u   = {32'd0, a} * {32'd0, b};
    assign w_div_zero = (b == 32'd0);

    // Select the product or quotient/remainder for the issuing op.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_a_neg  = (op == OP_DIV) && a[31];
        w_b_neg  = (op == OP_DIV) && b[31];
        w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
        w_b_mag  = w_b_neg ? (~b + 32'd1) : b;
        // Divisor forced non-zero so the divider never sees /0; the result is discarded anyway.
        w_dvsr   = w_div_zero ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_dvsr;
        w_r_mag  = w_a_mag % w_dvsr;
        case (op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                w_res_lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
                w_res_hi = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // Control FSM plus HI/LO and pending-result registers; reset wins over everything.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_res_hi <= w_res_hi;
                                r_res_lo <= w_res_lo;
                                r_res_wr <= 1'b1;
                                r_cnt    <= MUL_CNT;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_res_hi <= w_res_hi;
                                r_res_lo <= w_res_lo;
                                r_res_wr <= ~w_div_zero;
                                r_cnt    <= DIV_CNT;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // start is ignored here; upstream must stall.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
